// File: rtl/ap_ctrl_pkg.sv
// ap_ctrl_pkg
// Shared types for the ap_ctrl_hs initiator: FSM state encoding, the
// per-transaction status record and a helper that yields the all-ones
// (saturation) value for a given counter width.
package ap_ctrl_pkg;

    // Widths of the stored status record. The driver's CNT_W / IDX_W
    // parameters must not exceed these.
    localparam int REC_IDX_W = 16;
    localparam int REC_CNT_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_DONE,
        S_REPORT,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [REC_IDX_W-1:0] idx;
        logic [REC_CNT_W-1:0] ii;
        logic [REC_CNT_W-1:0] latency;
        logic                 timeout;
    } rec_t;

    // All-ones value of a width-bit counter, as a 64-bit constant.
    function automatic logic [63:0] sat_max(input int unsigned width);
        if (width >= 64)
            return '1;
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/ap_ctrl_driver_if.sv
// ap_ctrl_driver_if
// Kernel handshake (ap_ctrl_hs) plus the status-record channel.
//   master : the driver  - drives ap_start/ap_continue and the record
//   slave  : kernel/sink - drives ap_ready/ap_done and rec_ready
interface ap_ctrl_driver_if
    import ap_ctrl_pkg::*;
#(
    parameter int CNT_W = REC_CNT_W,
    parameter int IDX_W = REC_IDX_W
);
    logic             ap_start;
    logic             ap_continue;
    logic             ap_ready;
    logic             ap_done;
    logic             rec_valid;
    logic             rec_ready;
    logic [IDX_W-1:0] rec_idx;
    logic [CNT_W-1:0] rec_ii;
    logic [CNT_W-1:0] rec_latency;
    logic             rec_timeout;

    modport master (
        output ap_start, ap_continue, rec_valid, rec_idx, rec_ii, rec_latency, rec_timeout,
        input  ap_ready, ap_done, rec_ready
    );

    modport slave (
        input  ap_start, ap_continue, rec_valid, rec_idx, rec_ii, rec_latency, rec_timeout,
        output ap_ready, ap_done, rec_ready
    );
endinterface

// File: rtl/ap_ctrl_driver_sat_counter.sv
// sat_counter
// Up-counter with synchronous clear and enable that sticks at all-ones.
// Ports: clock, reset (async, active-low), clr, en, count[W-1:0].
module sat_counter
    import ap_ctrl_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);
    localparam logic [W-1:0] MAX = W'(sat_max(W));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en && (count != MAX))
            count <= count + W'(1);
    end
endmodule

// File: rtl/ap_ctrl_driver.sv
// ap_ctrl_driver
// Initiator for the ap_ctrl_hs block-level handshake. Runs cfg_num_txn
// non-overlapped kernel transactions and emits one status record each
// (start-to-ready and start-to-done cycle counts).
// Ports: clock, reset (async, active-low); cfg_start/cfg_num_txn/cfg_abort
// run control; bus (kernel handshake + record channel, master side);
// busy/finish/err_timeout status.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | after reset, waiting for cfg_start
// START     | ap_start high, waiting for ap_ready
// WAIT_DONE | inputs accepted, waiting for ap_done
// REPORT    | record valid, waiting for rec_ready
// DONE      | run finished or aborted, finish high until next cfg_start
module ap_ctrl_driver
    import ap_ctrl_pkg::*;
#(
    parameter int          CNT_W   = REC_CNT_W,
    parameter int          IDX_W   = REC_IDX_W,
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cfg_start,
    input  logic [IDX_W-1:0]   cfg_num_txn,
    input  logic               cfg_abort,
    ap_ctrl_driver_if.master   bus,
    output logic               busy,
    output logic               finish,
    output logic               err_timeout
);
    // Fields the transaction never reached read as CNT_W all-ones.
    localparam logic [REC_CNT_W-1:0] UNREACHED = REC_CNT_W'(sat_max(CNT_W));

    state_t                 state;
    rec_t                   rec_r;
    logic [IDX_W-1:0]       num_txn;
    logic                   ap_start_r;
    logic                   rec_valid_r;
    logic [CNT_W-1:0]       cnt;
    logic [REC_CNT_W-1:0]   cnt_rec;
    logic                   cnt_run;
    logic                   timeout_hit;
    logic [IDX_W-1:0]       idx_next;

    // Counter is held at zero outside START/WAIT_DONE, so it reads 0 in the
    // first ap_start cycle and k in cycle k.
    assign cnt_run = (state == S_START) || (state == S_WAIT_DONE);

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clock (clock),
        .reset (reset),
        .clr   (!cnt_run),
        .en    (cnt_run),
        .count (cnt)
    );

    assign cnt_rec     = REC_CNT_W'(cnt);
    // >= rather than == so a timeout is not skipped when ap_ready lands on
    // the TIMEOUT cycle and the FSM moves on to WAIT_DONE.
    assign timeout_hit = (TIMEOUT != 0) && (cnt >= CNT_W'(TIMEOUT));
    assign idx_next    = IDX_W'(rec_r.idx) + IDX_W'(1);

    assign bus.ap_start    = ap_start_r;
    assign bus.rec_valid   = rec_valid_r;
    assign bus.rec_idx     = IDX_W'(rec_r.idx);
    assign bus.rec_ii      = CNT_W'(rec_r.ii);
    assign bus.rec_latency = CNT_W'(rec_r.latency);
    assign bus.rec_timeout = rec_r.timeout;
    // A timed-out kernel never raised ap_done, so it must not be acknowledged.
    assign bus.ap_continue = (state == S_REPORT) && !rec_r.timeout && bus.rec_ready;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            num_txn     <= '0;
            rec_r       <= '0;
            ap_start_r  <= 1'b0;
            rec_valid_r <= 1'b0;
            busy        <= 1'b0;
            finish      <= 1'b0;
            err_timeout <= 1'b0;
        end else if (cfg_abort && (state inside {S_START, S_WAIT_DONE, S_REPORT})) begin
            // Abort beats a same-cycle record accept; the pending record is dropped.
            state       <= S_DONE;
            ap_start_r  <= 1'b0;
            rec_valid_r <= 1'b0;
            busy        <= 1'b0;
            finish      <= 1'b1;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (cfg_start) begin
                        num_txn     <= cfg_num_txn;
                        err_timeout <= 1'b0;
                        rec_r       <= '{idx: '0, ii: UNREACHED, latency: UNREACHED, timeout: 1'b0};
                        if (cfg_num_txn == '0) begin
                            state  <= S_DONE;
                            finish <= 1'b1;
                        end else begin
                            state      <= S_START;
                            ap_start_r <= 1'b1;
                            busy       <= 1'b1;
                            finish     <= 1'b0;
                        end
                    end
                end
                S_START: begin
                    if (bus.ap_ready) begin
                        rec_r.ii   <= cnt_rec;
                        ap_start_r <= 1'b0;
                        if (bus.ap_done) begin
                            rec_r.latency <= cnt_rec;
                            rec_valid_r   <= 1'b1;
                            state         <= S_REPORT;
                        end else begin
                            state <= S_WAIT_DONE;
                        end
                    end else if (timeout_hit) begin
                        ap_start_r    <= 1'b0;
                        rec_r.timeout <= 1'b1;
                        err_timeout   <= 1'b1;
                        rec_valid_r   <= 1'b1;
                        state         <= S_REPORT;
                    end
                end
                S_WAIT_DONE: begin
                    if (bus.ap_done) begin
                        rec_r.latency <= cnt_rec;
                        rec_valid_r   <= 1'b1;
                        state         <= S_REPORT;
                    end else if (timeout_hit) begin
                        rec_r.timeout <= 1'b1;
                        err_timeout   <= 1'b1;
                        rec_valid_r   <= 1'b1;
                        state         <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (bus.rec_ready) begin
                        rec_valid_r <= 1'b0;
                        if (rec_r.timeout || (idx_next == num_txn)) begin
                            state  <= S_DONE;
                            busy   <= 1'b0;
                            finish <= 1'b1;
                        end else begin
                            state      <= S_START;
                            ap_start_r <= 1'b1;
                            rec_r      <= '{idx: REC_IDX_W'(idx_next), ii: UNREACHED,
                                            latency: UNREACHED, timeout: 1'b0};
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ap_ctrl_driver.sv
module tb_ap_ctrl_driver;
    localparam int          CNT_W   = 32;
    localparam int          IDX_W   = 16;
    localparam int unsigned TIMEOUT = 20;
    localparam logic [CNT_W-1:0] ONES = {CNT_W{1'b1}};

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             cfg_start = 1'b0;
    logic             cfg_abort = 1'b0;
    logic [IDX_W-1:0] cfg_num_txn = '0;
    logic             busy;
    logic             finish;
    logic             err_timeout;

    ap_ctrl_driver_if #(.CNT_W(CNT_W), .IDX_W(IDX_W)) bus ();

    ap_ctrl_driver #(.CNT_W(CNT_W), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
        .clock       (clock),
        .reset       (reset),
        .cfg_start   (cfg_start),
        .cfg_num_txn (cfg_num_txn),
        .cfg_abort   (cfg_abort),
        .bus         (bus),
        .busy        (busy),
        .finish      (finish),
        .err_timeout (err_timeout)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [CNT_W-1:0] ii;
        logic [CNT_W-1:0] lat;
        logic             to;
    } trec_t;

    int errors = 0;
    int checks = 0;

    // Kernel stimulus: ap_ready pulses in cycle k_rdy_at, ap_done rises in
    // cycle k_done_at and is held until ap_continue is seen.
    int k_rdy_at  = 1000;
    int k_done_at = 1000;
    int k_epoch   = 0;

    initial begin
        int  seen;
        int  kc;
        bit  kbusy;
        bit  rel;
        seen = 0; kc = 0; kbusy = 1'b0; rel = 1'b0;
        bus.ap_ready = 1'b0;
        bus.ap_done  = 1'b0;
        forever begin
            @(negedge clock); #2;
            if (k_epoch != seen) begin
                seen = k_epoch; kbusy = 1'b0; rel = 1'b0;
            end
            if (rel) begin
                kbusy = 1'b0; rel = 1'b0;
            end
            if (!kbusy && bus.ap_start) begin
                kbusy = 1'b1; kc = 0;
            end else if (kbusy) begin
                kc++;
            end
            bus.ap_ready = kbusy && (kc == k_rdy_at);
            bus.ap_done  = kbusy && (kc >= k_done_at);
            rel = bus.ap_continue;
        end
    end

    // Observation: accepted records, ap_start rise cycles, high-cycle counts.
    trec_t recs[$];
    int    rise_cyc[$];
    int    start_hi = 0;
    int    cont_hi  = 0;
    int    cyc_n    = 0;

    always @(posedge clock) cyc_n <= cyc_n + 1;

    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge clock); #1;
            if (bus.ap_start) begin
                start_hi++;
                if (!prev) rise_cyc.push_back(cyc_n);
            end
            prev = bus.ap_start;
            if (bus.ap_continue) cont_hi++;
            if (bus.rec_valid && bus.rec_ready)
                recs.push_back('{idx: bus.rec_idx, ii: bus.rec_ii, lat: bus.rec_latency, to: bus.rec_timeout});
        end
    end

    task automatic test_reset();
        @(negedge clock);
        checks++;
        if ({bus.ap_start, bus.ap_continue, bus.rec_valid, bus.rec_timeout, busy, finish, err_timeout} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0000000",
                     {bus.ap_start, bus.ap_continue, bus.rec_valid, bus.rec_timeout, busy, finish, err_timeout});
        end
        checks++;
        if ({bus.rec_idx, bus.rec_ii, bus.rec_latency} !== '0) begin
            errors++;
            $display("FAIL reset_rec: got idx=%0d ii=%0d lat=%0d want 0", bus.rec_idx, bus.rec_ii, bus.rec_latency);
        end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_basic();
        int r0, s0, h0, c0, n;
        trec_t e;
        k_rdy_at = 0; k_done_at = 4; k_epoch++; bus.rec_ready = 1'b1;
        r0 = recs.size(); s0 = rise_cyc.size(); h0 = start_hi; c0 = cont_hi;
        @(negedge clock); cfg_num_txn = 16'd3; cfg_start = 1'b1;
        @(negedge clock); cfg_start = 1'b0;
        checks++;
        if ({bus.ap_start, busy, finish} !== 3'b110) begin
            errors++;
            $display("FAIL basic_first_start: got start/busy/finish=%b want 110", {bus.ap_start, busy, finish});
        end
        n = 0;
        while (!finish && n < 100) begin @(negedge clock); n++; end
        checks++;
        if ({finish, busy} !== 2'b10) begin
            errors++; $display("FAIL basic_finish: got finish/busy=%b want 10", {finish, busy});
        end
        checks++;
        if (recs.size() - r0 != 3) begin
            errors++; $display("FAIL basic_count: got %0d records want 3", recs.size() - r0);
        end
        for (int i = 0; i < 3; i++) begin
            if (recs.size() > r0 + i) begin
                e = '{idx: IDX_W'(i), ii: '0, lat: CNT_W'(4), to: 1'b0};
                checks++;
                if (recs[r0+i] !== e) begin
                    errors++;
                    $display("FAIL basic_rec%0d: got idx=%0d ii=%0d lat=%0d to=%0d want idx=%0d ii=0 lat=4 to=0",
                             i, recs[r0+i].idx, recs[r0+i].ii, recs[r0+i].lat, recs[r0+i].to, i);
                end
            end
        end
        for (int i = 1; i < 3; i++) begin
            if (rise_cyc.size() > s0 + i) begin
                checks++;
                if (rise_cyc[s0+i] - rise_cyc[s0+i-1] != 6) begin
                    errors++;
                    $display("FAIL basic_period%0d: got %0d cycles want 6", i, rise_cyc[s0+i] - rise_cyc[s0+i-1]);
                end
            end
        end
        checks++;
        if (start_hi - h0 != 3) begin
            errors++; $display("FAIL basic_start_cycles: got %0d want 3", start_hi - h0);
        end
        checks++;
        if (cont_hi - c0 != 3) begin
            errors++; $display("FAIL basic_continue: got %0d pulses want 3", cont_hi - c0);
        end
    endtask

    task automatic test_ii2();
        int r0, h0, n;
        trec_t e;
        k_rdy_at = 2; k_done_at = 9; k_epoch++; bus.rec_ready = 1'b1;
        r0 = recs.size(); h0 = start_hi;
        @(negedge clock); cfg_num_txn = 16'd1; cfg_start = 1'b1;
        @(negedge clock); cfg_start = 1'b0;
        n = 0;
        while (!finish && n < 100) begin @(negedge clock); n++; end
        checks++;
        if (finish !== 1'b1) begin
            errors++; $display("FAIL ii2_finish: got %b want 1", finish);
        end
        checks++;
        if (start_hi - h0 != 3) begin
            errors++; $display("FAIL ii2_start_cycles: got %0d want 3", start_hi - h0);
        end
        e = '{idx: '0, ii: CNT_W'(2), lat: CNT_W'(9), to: 1'b0};
        checks++;
        if (recs.size() != r0 + 1) begin
            errors++; $display("FAIL ii2_count: got %0d records want 1", recs.size() - r0);
        end else if (recs[r0] !== e) begin
            errors++;
            $display("FAIL ii2_rec: got idx=%0d ii=%0d lat=%0d to=%0d want idx=0 ii=2 lat=9 to=0",
                     recs[r0].idx, recs[r0].ii, recs[r0].lat, recs[r0].to);
        end
    endtask

    task automatic test_backpressure();
        int c0, n;
        k_rdy_at = 0; k_done_at = 3; k_epoch++; bus.rec_ready = 1'b0;
        c0 = cont_hi;
        @(negedge clock); cfg_num_txn = 16'd1; cfg_start = 1'b1;
        @(negedge clock); cfg_start = 1'b0;
        n = 0;
        while (!bus.rec_valid && n < 50) begin @(negedge clock); n++; end
        checks++;
        if (bus.rec_valid !== 1'b1) begin
            errors++; $display("FAIL bp_valid_wait: got rec_valid=%b want 1", bus.rec_valid);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.rec_valid, bus.ap_continue, bus.ap_done} !== 3'b101) begin
                errors++;
                $display("FAIL bp_hold%0d: got valid/continue/done=%b want 101", i,
                         {bus.rec_valid, bus.ap_continue, bus.ap_done});
            end
            checks++;
            if ({bus.rec_idx, bus.rec_ii, bus.rec_latency, bus.rec_timeout} !== {16'd0, 32'd0, 32'd3, 1'b0}) begin
                errors++;
                $display("FAIL bp_payload%0d: got idx=%0d ii=%0d lat=%0d to=%0d want idx=0 ii=0 lat=3 to=0", i,
                         bus.rec_idx, bus.rec_ii, bus.rec_latency, bus.rec_timeout);
            end
            @(negedge clock);
        end
        bus.rec_ready = 1'b1;
        #1;
        checks++;
        if (bus.ap_continue !== 1'b1) begin
            errors++; $display("FAIL bp_continue_on: got %b want 1", bus.ap_continue);
        end
        @(negedge clock);
        checks++;
        if ({bus.ap_continue, bus.rec_valid, finish} !== 3'b001) begin
            errors++;
            $display("FAIL bp_after_accept: got continue/valid/finish=%b want 001",
                     {bus.ap_continue, bus.rec_valid, finish});
        end
        checks++;
        if (cont_hi - c0 != 1) begin
            errors++; $display("FAIL bp_continue_len: got %0d cycles want 1", cont_hi - c0);
        end
    endtask

    task automatic test_timeout();
        int r0, h0, c0, n;
        trec_t e;
        k_rdy_at = 1000; k_done_at = 1000; k_epoch++; bus.rec_ready = 1'b1;
        r0 = recs.size(); h0 = start_hi; c0 = cont_hi;
        @(negedge clock); cfg_num_txn = 16'd2; cfg_start = 1'b1;
        @(negedge clock); cfg_start = 1'b0;
        n = 0;
        while (!finish && n < 60) begin @(negedge clock); n++; end
        checks++;
        if ({finish, err_timeout, busy} !== 3'b110) begin
            errors++; $display("FAIL to_status: got finish/err/busy=%b want 110", {finish, err_timeout, busy});
        end
        checks++;
        if (start_hi - h0 != 21) begin
            errors++; $display("FAIL to_start_cycles: got %0d want 21", start_hi - h0);
        end
        checks++;
        if (cont_hi - c0 != 0) begin
            errors++; $display("FAIL to_continue: got %0d pulses want 0", cont_hi - c0);
        end
        e = '{idx: '0, ii: ONES, lat: ONES, to: 1'b1};
        checks++;
        if (recs.size() != r0 + 1) begin
            errors++; $display("FAIL to_count: got %0d records want 1", recs.size() - r0);
        end else if (recs[r0] !== e) begin
            errors++;
            $display("FAIL to_rec: got idx=%0d ii=%h lat=%h to=%0d want idx=0 ii=%h lat=%h to=1",
                     recs[r0].idx, recs[r0].ii, recs[r0].lat, recs[r0].to, ONES, ONES);
        end
    endtask

    task automatic test_abort();
        int r0, r1, h1, n;
        bit hit;
        trec_t e;
        k_rdy_at = 1; k_done_at = 6; k_epoch++; bus.rec_ready = 1'b1;
        r0 = recs.size();
        @(negedge clock); cfg_num_txn = 16'd4; cfg_start = 1'b1;
        @(negedge clock); cfg_start = 1'b0;
        checks++;
        if ({err_timeout, finish} !== 2'b00) begin
            errors++; $display("FAIL abort_clear: got err/finish=%b want 00", {err_timeout, finish});
        end
        hit = 1'b0; n = 0;
        while (!hit && n < 60) begin
            @(negedge clock); #2; n++;
            hit = (recs.size() - r0 >= 1) && busy && !bus.ap_start && !bus.rec_valid;
        end
        checks++;
        if (!hit) begin
            errors++; $display("FAIL abort_reach_wait: got no WAIT_DONE in txn 1 want one");
        end
        cfg_abort = 1'b1;
        @(negedge clock); cfg_abort = 1'b0;
        checks++;
        if ({finish, busy, bus.ap_start, bus.rec_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL abort_done: got finish/busy/start/valid=%b want 1000",
                     {finish, busy, bus.ap_start, bus.rec_valid});
        end
        r1 = recs.size(); h1 = start_hi;
        repeat (15) @(negedge clock);
        checks++;
        if (recs.size() != r1 || start_hi != h1 || bus.ap_start !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d new records %0d start cycles want 0 0",
                     recs.size() - r1, start_hi - h1);
        end
        e = '{idx: '0, ii: CNT_W'(1), lat: CNT_W'(6), to: 1'b0};
        checks++;
        if (recs.size() != r0 + 1) begin
            errors++; $display("FAIL abort_count: got %0d records want 1", recs.size() - r0);
        end else if (recs[r0] !== e) begin
            errors++;
            $display("FAIL abort_rec: got idx=%0d ii=%0d lat=%0d to=%0d want idx=0 ii=1 lat=6 to=0",
                     recs[r0].idx, recs[r0].ii, recs[r0].lat, recs[r0].to);
        end
    endtask

    task automatic test_reset_mid();
        k_rdy_at = 1000; k_done_at = 1000; k_epoch++; bus.rec_ready = 1'b1;
        @(negedge clock); cfg_num_txn = 16'd1; cfg_start = 1'b1;
        @(negedge clock); cfg_start = 1'b0;
        @(negedge clock);
        checks++;
        if ({bus.ap_start, busy} !== 2'b11) begin
            errors++; $display("FAIL rmid_pre: got start/busy=%b want 11", {bus.ap_start, busy});
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({bus.ap_start, bus.ap_continue, bus.rec_valid, bus.rec_timeout, busy, finish, err_timeout,
             bus.rec_idx, bus.rec_ii, bus.rec_latency} !== '0) begin
            errors++;
            $display("FAIL rmid_async: got start=%b busy=%b finish=%b valid=%b want all 0",
                     bus.ap_start, busy, finish, bus.rec_valid);
        end
        @(negedge clock); reset = 1'b1;
        k_epoch++;
        @(negedge clock);
    endtask

    task automatic test_zero();
        int h0;
        h0 = start_hi;
        @(negedge clock); cfg_num_txn = 16'd0; cfg_start = 1'b1;
        @(negedge clock); cfg_start = 1'b0;
        checks++;
        if ({finish, busy, bus.ap_start} !== 3'b100) begin
            errors++; $display("FAIL zero_done: got finish/busy/start=%b want 100", {finish, busy, bus.ap_start});
        end
        repeat (5) @(negedge clock);
        checks++;
        if (start_hi != h0) begin
            errors++; $display("FAIL zero_no_start: got %0d start cycles want 0", start_hi - h0);
        end
    endtask

    initial begin
        bus.rec_ready = 1'b0;
        test_reset();
        test_basic();
        test_ii2();
        test_backpressure();
        test_timeout();
        test_abort();
        test_reset_mid();
        test_zero();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
